pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the five-stage pipeline. It generates stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline registers. It also sequences the data-memory access of the instruction in M through a request/ready handshake, freezing the pipeline while memory is busy and flagging a sticky error on timeout. It sits beside the pipeline registers and is clocked on the same edge they capture on.

## Interface
Parameters:
- TIMEOUT, default 255: maximum WAIT cycles before ERR is raised; must be 1..2^CNT_W-1.
- CNT_W, default 8: width of the wait counter.

Ports (clock, reset first):
- CLK  in  1  system clock; all state captures on negedge CLK, the same edge as the pipeline registers.
- CLR  in  1  reset, asynchronous, active-high.
- RS_D, RT_D  in  5 each  source registers of the instruction in D.
- RS_E, RT_E  in  5 each  source registers of the instruction in E.
- WRITE_REG_E, WRITE_REG_M, WRITE_REG_W  in  5 each  destination registers.
- REG_WRITE_E, REG_WRITE_M, REG_WRITE_W  in  1 each  register write enables.
- MEM_TO_REG_E, MEM_TO_REG_M  in  1 each  load indicators.
- MEM_WRITE_M  in  1  store in M.
- BRANCH_D  in  1  branch resolving in D.
- MEM_READY  in  1  data memory completes the current access this cycle.
- STALL_F, STALL_D  out  1 each  hold the PC and F/D registers.
- STALL_E, STALL_M  out  1 each  hold the D/E, E/M and M/W registers (memory freeze).
- FLUSH_E  out  1  clear D/E, inserting a bubble.
- FORWARD_AE, FORWARD_BE  out  2 each  E operand select: 00 register file, 01 from W, 10 from M.
- FORWARD_AD, FORWARD_BD  out  1 each  D branch comparator operand from the M ALU result.
- MEM_REQ  out  1  data memory access request.
- BUSY  out  1  memory FSM in WAIT.
- ERR  out  1  sticky timeout flag.

## Operation
Register 0 never matches any hazard or forward comparison.

**Forwarding (combinational)**
- FORWARD_AE = 10 if REG_WRITE_M and WRITE_REG_M==RS_E.
- Otherwise FORWARD_AE = 01 if REG_WRITE_W and WRITE_REG_W==RS_E.
- Otherwise FORWARD_AE = 00.
- FORWARD_BE is the same, using RT_E. M has priority over W.
- FORWARD_AD = REG_WRITE_M and WRITE_REG_M==RS_D. FORWARD_BD is the same, using RT_D.

**Hazard stalls**
- lwstall = MEM_TO_REG_E and (WRITE_REG_E==RS_D or WRITE_REG_E==RT_D).
- brstall = BRANCH_D and either:
  - REG_WRITE_E and WRITE_REG_E matches RS_D or RT_D, or
  - MEM_TO_REG_M and WRITE_REG_M matches RS_D or RT_D.
- hz = lwstall or brstall.

**Memory FSM** (states IDLE, WAIT; counter cnt)
- memop = MEM_TO_REG_M or MEM_WRITE_M.
- MEM_REQ = memop in IDLE, and 1 in WAIT; forced 0 while CLR is high.
- memstall = MEM_REQ and not MEM_READY.
- IDLE to WAIT: on the negedge with memop and not MEM_READY; cnt is loaded with 1.
- IDLE with memop and MEM_READY: zero-cycle access, stay in IDLE, no stall.
- WAIT to IDLE: on the negedge with MEM_READY. The pipeline advances on that same edge, so the next M instruction is evaluated fresh in IDLE.
- WAIT without MEM_READY: cnt increments, saturating at 2^CNT_W-1. When cnt==TIMEOUT and MEM_READY is low, ERR is set. The FSM stays in WAIT; ERR does not abort the access.
- BUSY = (state==WAIT).

**Output priority**
- memstall: STALL_F, STALL_D, STALL_E and STALL_M all 1; FLUSH_E=0. The whole pipeline freezes and no bubble is inserted.
- Else hz: STALL_F=STALL_D=1, FLUSH_E=1, STALL_E=STALL_M=0.
- Else all stall and flush outputs are 0.

## Timing
- Reset: CLR asynchronously forces state=IDLE, cnt=0, ERR=0 and MEM_REQ=0, with all stall and flush outputs 0.
- Stall, flush, forward and MEM_REQ outputs are combinational from inputs and state. They settle within the high phase so that the negedge capture sees them.
- Load-use costs exactly one bubble.
- A memory access with N ready-low cycles freezes the pipeline for exactly N negedges.
- Reset mid-WAIT: the FSM immediately returns to IDLE and MEM_REQ drops in the same cycle; a pending access is abandoned.
- Simultaneous memstall and hz: the freeze wins. The hazard is re-evaluated after release, because the D/E contents are unchanged.
- ERR clears only on CLR.

## Configuration
- FORWARD_EN defined: forwarding as described above.
- FORWARD_EN undefined:
  - All FORWARD_* outputs are tied to 0.
  - hz additionally includes any RAW match of RS_D or RT_D against WRITE_REG_E (with REG_WRITE_E) or against WRITE_REG_M (with REG_WRITE_M).
  - W is not checked, because the register file writes before it reads.
  - The memory FSM is unchanged.

## Test plan
- Forwarding: M writes r5 and W writes r5, RS_E=5 -> FORWARD_AE=10. RS_E=0 with a writer of r0 -> 00.
- Load-use: MEM_TO_REG_E=1, WRITE_REG_E=3, RT_D=3 -> STALL_F=STALL_D=FLUSH_E=1 for one cycle, then all 0 once the load moves to M.
- Memory wait: memop in M, MEM_READY low for 3 cycles -> BUSY high for 3 negedges, all STALL_* outputs 1, FLUSH_E=0, then release on the ready cycle.
- Simultaneous memory freeze and branch hazard: FLUSH_E stays 0 during the freeze. After release, FLUSH_E pulses once if the hazard persists.
- Timeout: TIMEOUT=4, MEM_READY held low -> ERR rises after the 4th WAIT cycle and stays 1 after ready. CLR clears it.
- CLR asserted mid-WAIT: MEM_REQ, BUSY and stalls drop to 0 asynchronously. With FORWARD_EN undefined, an ALU RAW hazard in E stalls one cycle and the FORWARD_* outputs stay 00.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall, flush and forwarding control for a five-stage pipeline, plus the
// data-memory request/ready sequencer. Optional feature macro: FORWARD_EN.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [4:0] RS_D,
    input  logic [4:0] RT_D,
    input  logic [4:0] RS_E,
    input  logic [4:0] RT_E,
    input  logic [4:0] WRITE_REG_E,
    input  logic [4:0] WRITE_REG_M,
    input  logic [4:0] WRITE_REG_W,
    input  logic       REG_WRITE_E,
    input  logic       REG_WRITE_M,
    input  logic       REG_WRITE_W,
    input  logic       MEM_TO_REG_E,
    input  logic       MEM_TO_REG_M,
    input  logic       MEM_WRITE_M,
    input  logic       BRANCH_D,
    input  logic       MEM_READY,
    output logic       STALL_F,
    output logic       STALL_D,
    output logic       STALL_E,
    output logic       STALL_M,
    output logic       FLUSH_E,
    output logic [1:0] FORWARD_AE,
    output logic [1:0] FORWARD_BE,
    output logic       FORWARD_AD,
    output logic       FORWARD_BD,
    output logic       MEM_REQ,
    output logic       BUSY,
    output logic       ERR
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic w_memop;
    logic w_mem_req;
    logic w_memstall;
    logic w_lwstall;
    logic w_brstall;
    logic w_raw;
    logic w_hz;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic f_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    assign w_memop    = MEM_TO_REG_M | MEM_WRITE_M;
    assign w_mem_req  = !CLR && ((r_state == WAIT) || w_memop);
    assign w_memstall = w_mem_req && !MEM_READY;

    assign w_lwstall = MEM_TO_REG_E && (f_hit(WRITE_REG_E, RS_D) || f_hit(WRITE_REG_E, RT_D));
    assign w_brstall = BRANCH_D &&
        ((REG_WRITE_E  && (f_hit(WRITE_REG_E, RS_D) || f_hit(WRITE_REG_E, RT_D))) ||
         (MEM_TO_REG_M && (f_hit(WRITE_REG_M, RS_D) || f_hit(WRITE_REG_M, RT_D))));

`ifdef FORWARD_EN
    assign w_raw = 1'b0;

    always_comb begin
        FORWARD_AE = 2'b00;
        FORWARD_BE = 2'b00;
        if (REG_WRITE_M && f_hit(WRITE_REG_M, RS_E))      FORWARD_AE = 2'b10;
        else if (REG_WRITE_W && f_hit(WRITE_REG_W, RS_E)) FORWARD_AE = 2'b01;
        if (REG_WRITE_M && f_hit(WRITE_REG_M, RT_E))      FORWARD_BE = 2'b10;
        else if (REG_WRITE_W && f_hit(WRITE_REG_W, RT_E)) FORWARD_BE = 2'b01;
    end

    assign FORWARD_AD = REG_WRITE_M && f_hit(WRITE_REG_M, RS_D);
    assign FORWARD_BD = REG_WRITE_M && f_hit(WRITE_REG_M, RT_D);
`else
    // Without bypass paths any pending E or M write to a D source must wait;
    // W is safe because the register file writes before it reads.
    assign w_raw =
        (REG_WRITE_E && (f_hit(WRITE_REG_E, RS_D) || f_hit(WRITE_REG_E, RT_D))) ||
        (REG_WRITE_M && (f_hit(WRITE_REG_M, RS_D) || f_hit(WRITE_REG_M, RT_D)));

    assign FORWARD_AE = 2'b00;
    assign FORWARD_BE = 2'b00;
    assign FORWARD_AD = 1'b0;
    assign FORWARD_BD = 1'b0;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{RS_E, RT_E, WRITE_REG_W, REG_WRITE_W};
`endif

    assign w_hz = !CLR && (w_lwstall || w_brstall || w_raw);

    // A memory freeze outranks a hazard: flushing D/E while E/M is held would lose an instruction.
    always_comb begin
        STALL_F = 1'b0;
        STALL_D = 1'b0;
        STALL_E = 1'b0;
        STALL_M = 1'b0;
        FLUSH_E = 1'b0;
        if (w_memstall) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            STALL_E = 1'b1;
            STALL_M = 1'b1;
        end else if (w_hz) begin
            STALL_F = 1'b1;
            STALL_D = 1'b1;
            FLUSH_E = 1'b1;
        end
    end

    // NOTE: state captures on negedge CLK alongside the pipeline registers; use <= only here.
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memop && !MEM_READY) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_ONE;
                    end
                end
                WAIT: begin
                    if (MEM_READY) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == CNT_TO)  r_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MEM_REQ = w_mem_req;
    assign BUSY    = (r_state == WAIT);
    assign ERR     = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [4:0] RS_D, RT_D, RS_E, RT_E;
    logic [4:0] WRITE_REG_E, WRITE_REG_M, WRITE_REG_W;
    logic       REG_WRITE_E, REG_WRITE_M, REG_WRITE_W;
    logic       MEM_TO_REG_E, MEM_TO_REG_M, MEM_WRITE_M;
    logic       BRANCH_D, MEM_READY;
    logic       STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_E;
    logic [1:0] FORWARD_AE, FORWARD_BE;
    logic       FORWARD_AD, FORWARD_BD;
    logic       MEM_REQ, BUSY, ERR;

    int n_chk = 0;
    int n_err = 0;

    // Model state: consecutive ready-low negedges seen by the outstanding access.
    int m_low = 0;
    bit m_err = 1'b0;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .CLK(CLK), .CLR(CLR),
        .RS_D(RS_D), .RT_D(RT_D), .RS_E(RS_E), .RT_E(RT_E),
        .WRITE_REG_E(WRITE_REG_E), .WRITE_REG_M(WRITE_REG_M), .WRITE_REG_W(WRITE_REG_W),
        .REG_WRITE_E(REG_WRITE_E), .REG_WRITE_M(REG_WRITE_M), .REG_WRITE_W(REG_WRITE_W),
        .MEM_TO_REG_E(MEM_TO_REG_E), .MEM_TO_REG_M(MEM_TO_REG_M), .MEM_WRITE_M(MEM_WRITE_M),
        .BRANCH_D(BRANCH_D), .MEM_READY(MEM_READY),
        .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E), .STALL_M(STALL_M),
        .FLUSH_E(FLUSH_E),
        .FORWARD_AE(FORWARD_AE), .FORWARD_BE(FORWARD_BE),
        .FORWARD_AD(FORWARD_AD), .FORWARD_BD(FORWARD_BD),
        .MEM_REQ(MEM_REQ), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int actual, input int expected);
        n_chk++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // A memory access completes on a ready negedge; each ready-low negedge lengthens it.
    // The timeout fires on the low negedge where the wait count reaches TIMEOUT.
    always @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            m_low = 0;
            m_err = 1'b0;
        end else if (m_low > 0 || MEM_TO_REG_M || MEM_WRITE_M) begin
            if (MEM_READY) begin
                m_low = 0;
            end else begin
                m_low++;
                if (m_low == TIMEOUT + 1) m_err = 1'b1;
            end
        end
    end

    // Compare process: one cycle-wide check just before every capturing negedge.
    always @(posedge CLK) begin : cmp
        bit e_req, e_ms, e_lw, e_br, e_raw, e_hz;
        int e_fae, e_fbe, e_fad, e_fbd;
        #4;
        e_req = !CLR && (m_low > 0 || MEM_TO_REG_M || MEM_WRITE_M);
        e_ms  = e_req && !MEM_READY;
        e_lw  = MEM_TO_REG_E && (hit(WRITE_REG_E, RS_D) || hit(WRITE_REG_E, RT_D));
        e_br  = BRANCH_D &&
                ((REG_WRITE_E && (hit(WRITE_REG_E, RS_D) || hit(WRITE_REG_E, RT_D))) ||
                 (MEM_TO_REG_M && (hit(WRITE_REG_M, RS_D) || hit(WRITE_REG_M, RT_D))));
`ifdef FORWARD_EN
        e_raw = 1'b0;
        e_fae = (REG_WRITE_M && hit(WRITE_REG_M, RS_E)) ? 2 :
                (REG_WRITE_W && hit(WRITE_REG_W, RS_E)) ? 1 : 0;
        e_fbe = (REG_WRITE_M && hit(WRITE_REG_M, RT_E)) ? 2 :
                (REG_WRITE_W && hit(WRITE_REG_W, RT_E)) ? 1 : 0;
        e_fad = int'(REG_WRITE_M && hit(WRITE_REG_M, RS_D));
        e_fbd = int'(REG_WRITE_M && hit(WRITE_REG_M, RT_D));
`else
        e_raw = (REG_WRITE_E && (hit(WRITE_REG_E, RS_D) || hit(WRITE_REG_E, RT_D))) ||
                (REG_WRITE_M && (hit(WRITE_REG_M, RS_D) || hit(WRITE_REG_M, RT_D)));
        e_fae = 0; e_fbe = 0; e_fad = 0; e_fbd = 0;
`endif
        e_hz = !CLR && (e_lw || e_br || e_raw);
        check("cmp_STALL_F", int'(STALL_F), int'(e_ms || e_hz));
        check("cmp_STALL_D", int'(STALL_D), int'(e_ms || e_hz));
        check("cmp_STALL_E", int'(STALL_E), int'(e_ms));
        check("cmp_STALL_M", int'(STALL_M), int'(e_ms));
        check("cmp_FLUSH_E", int'(FLUSH_E), int'(!e_ms && e_hz));
        check("cmp_FORWARD_AE", int'(FORWARD_AE), e_fae);
        check("cmp_FORWARD_BE", int'(FORWARD_BE), e_fbe);
        check("cmp_FORWARD_AD", int'(FORWARD_AD), e_fad);
        check("cmp_FORWARD_BD", int'(FORWARD_BD), e_fbd);
        check("cmp_MEM_REQ", int'(MEM_REQ), int'(e_req));
        check("cmp_BUSY", int'(BUSY), int'(m_low > 0));
        check("cmp_ERR", int'(ERR), int'(m_err));
    end

    task automatic clear_inputs();
        RS_D = 0; RT_D = 0; RS_E = 0; RT_E = 0;
        WRITE_REG_E = 0; WRITE_REG_M = 0; WRITE_REG_W = 0;
        REG_WRITE_E = 0; REG_WRITE_M = 0; REG_WRITE_W = 0;
        MEM_TO_REG_E = 0; MEM_TO_REG_M = 0; MEM_WRITE_M = 0;
        BRANCH_D = 0; MEM_READY = 1;
    endtask

    // Inputs change 1 time unit after posedge, far from the capturing negedge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        CLR = 1'b1;
        clear_inputs();
        MEM_TO_REG_M = 1'b1;
        MEM_READY    = 1'b0;
        #3;
        check("rst_MEM_REQ", int'(MEM_REQ), 0);
        check("rst_BUSY", int'(BUSY), 0);
        check("rst_ERR", int'(ERR), 0);
        check("rst_STALL_F", int'(STALL_F), 0);
        check("rst_STALL_M", int'(STALL_M), 0);

        // Forwarding priority and the r0 exclusion.
        next_cycle(); CLR = 1'b0; clear_inputs();
        REG_WRITE_M = 1; WRITE_REG_M = 5; REG_WRITE_W = 1; WRITE_REG_W = 5; RS_E = 5;
        settle();
`ifdef FORWARD_EN
        check("fwd_m_over_w", int'(FORWARD_AE), 2);
`else
        check("fwd_m_over_w", int'(FORWARD_AE), 0);
`endif
        next_cycle(); REG_WRITE_M = 0;
        settle();
`ifdef FORWARD_EN
        check("fwd_w_only", int'(FORWARD_AE), 1);
`else
        check("fwd_w_only", int'(FORWARD_AE), 0);
`endif
        next_cycle(); REG_WRITE_M = 1; WRITE_REG_M = 0; WRITE_REG_W = 0; RS_E = 0;
        settle();
        check("fwd_r0", int'(FORWARD_AE), 0);

        // Load-use: one bubble, then clear once the load reaches M (zero-cycle access).
        next_cycle(); clear_inputs();
        MEM_TO_REG_E = 1; WRITE_REG_E = 3; RT_D = 3;
        settle();
        check("lu_STALL_F", int'(STALL_F), 1);
        check("lu_STALL_D", int'(STALL_D), 1);
        check("lu_FLUSH_E", int'(FLUSH_E), 1);
        check("lu_STALL_E", int'(STALL_E), 0);
        next_cycle(); clear_inputs();
        MEM_TO_REG_M = 1; WRITE_REG_M = 3; MEM_READY = 1;
        settle();
        check("lu_after_STALL_F", int'(STALL_F), 0);
        check("lu_after_FLUSH_E", int'(FLUSH_E), 0);
        check("lu_after_MEM_REQ", int'(MEM_REQ), 1);
        check("lu_after_STALL_M", int'(STALL_M), 0);

        // Three ready-low cycles with a branch hazard behind the freeze.
        next_cycle(); clear_inputs();
        MEM_TO_REG_M = 1; MEM_READY = 0;
        BRANCH_D = 1; REG_WRITE_E = 1; WRITE_REG_E = 7; RS_D = 7;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            settle();
            check($sformatf("mw%0d_STALL_M", i), int'(STALL_M), 1);
            check($sformatf("mw%0d_FLUSH_E", i), int'(FLUSH_E), 0);
            check($sformatf("mw%0d_BUSY", i), int'(BUSY), (i > 0) ? 1 : 0);
        end
        next_cycle(); MEM_READY = 1;
        settle();
        check("mw_rel_BUSY", int'(BUSY), 1);
        check("mw_rel_STALL_E", int'(STALL_E), 0);
        check("mw_rel_FLUSH_E", int'(FLUSH_E), 1);
        next_cycle(); clear_inputs();
        settle();
        check("mw_done_BUSY", int'(BUSY), 0);
        check("mw_done_FLUSH_E", int'(FLUSH_E), 0);

        // Timeout after the 4th WAIT cycle; sticky past ready.
        next_cycle(); clear_inputs(); MEM_WRITE_M = 1; MEM_READY = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            settle();
            check($sformatf("to%0d_ERR", i), int'(ERR), 0);
        end
        next_cycle(); MEM_READY = 1;
        settle();
        check("to_ERR_set", int'(ERR), 1);
        next_cycle(); clear_inputs();
        settle();
        check("to_ERR_sticky", int'(ERR), 1);

        // CLR mid-WAIT drops everything asynchronously and clears ERR.
        next_cycle(); MEM_TO_REG_M = 1; MEM_READY = 0;
        next_cycle();
        #1; CLR = 1'b1;
        #1;
        check("clr_MEM_REQ", int'(MEM_REQ), 0);
        check("clr_BUSY", int'(BUSY), 0);
        check("clr_STALL_F", int'(STALL_F), 0);
        check("clr_STALL_M", int'(STALL_M), 0);
        check("clr_ERR", int'(ERR), 0);
        next_cycle(); CLR = 1'b0; clear_inputs();

        // ALU RAW from E into D, then an M writer feeding E.
        next_cycle(); REG_WRITE_E = 1; WRITE_REG_E = 9; RS_D = 9;
        settle();
`ifdef FORWARD_EN
        check("raw_STALL_F", int'(STALL_F), 0);
`else
        check("raw_STALL_F", int'(STALL_F), 1);
        check("raw_FLUSH_E", int'(FLUSH_E), 1);
`endif
        next_cycle(); clear_inputs(); REG_WRITE_M = 1; WRITE_REG_M = 9; RS_E = 9;
        settle();
`ifdef FORWARD_EN
        check("raw_FORWARD_AE", int'(FORWARD_AE), 2);
`else
        check("raw_FORWARD_AE", int'(FORWARD_AE), 0);
`endif

        // Randomized traffic, checked each cycle by the compare process.
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            RS_D = 5'($urandom_range(0, 3));
            RT_D = 5'($urandom_range(0, 3));
            RS_E = 5'($urandom_range(0, 3));
            RT_E = 5'($urandom_range(0, 3));
            WRITE_REG_E = 5'($urandom_range(0, 3));
            WRITE_REG_M = 5'($urandom_range(0, 3));
            WRITE_REG_W = 5'($urandom_range(0, 3));
            REG_WRITE_E = 1'($urandom_range(0, 1));
            REG_WRITE_M = 1'($urandom_range(0, 1));
            REG_WRITE_W = 1'($urandom_range(0, 1));
            MEM_TO_REG_E = 1'($urandom_range(0, 1));
            MEM_TO_REG_M = ($urandom_range(0, 3) == 0);
            MEM_WRITE_M  = ($urandom_range(0, 3) == 0);
            BRANCH_D     = 1'($urandom_range(0, 1));
            MEM_READY    = ($urandom_range(0, 9) < 6);
            CLR          = ($urandom_range(0, 99) == 0);
        end
        next_cycle(); CLR = 1'b0; clear_inputs();
        next_cycle();
        #6;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
